// File: rtl/freqin.sv
// rtl/freqin.sv - period measurement of an asynchronous square wave
// Synchronize, deglitch, then time the spacing of accepted rising edges.
module freqin #(
    parameter int          SYNC_STAGES = 2,
    parameter int          FILTER      = 4,
    parameter logic [31:0] TIMEOUT     = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freq_in,
    output logic [31:0] period,
    output logic        valid,
    output logic        timeout,
    output logic [15:0] edge_count
);

    localparam int            FW   = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [FW-1:0] FLIM = FW'(FILTER - 1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   filt_q;
    logic                   filt_d;
    logic [FW-1:0]          fcnt;
    logic                   rise;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] period_n;
    logic        valid_n;
    logic        timeout_n;
    logic [15:0] edges_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], freq_in};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The filtered level only moves after FILTER consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            filt_d <= 1'b0;
            fcnt   <= '0;
        end else begin
            filt_d <= filt_q;
            if (synced == filt_q) begin
                fcnt <= '0;
            end else if (fcnt == FLIM) begin
                filt_q <= synced;
                fcnt   <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign rise = filt_q & ~filt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            edge_count <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            period     <= period_n;
            valid      <= valid_n;
            timeout    <= timeout_n;
            edge_count <= edges_n;
        end
    end

    // Leaving MEASURE at TIMEOUT keeps the counter from ever passing it.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        period_n  = period;
        valid_n   = 1'b0;
        timeout_n = timeout;
        edges_n   = rise ? edge_count + 16'd1 : edge_count;
        case (state)
            IDLE: begin
                if (rise) begin
                    cnt_n   = 32'd1;
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_n  = cnt;
                    valid_n   = 1'b1;
                    timeout_n = 1'b0;
                    cnt_n     = 32'd1;
                end else if (cnt == TIMEOUT) begin
                    period_n  = '0;
                    timeout_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_freqin.sv
// tb/tb_freqin.sv - self-checking bench for freqin
// Timestamp-based reference model plus table and directed corner sequences.
module tb_freqin;

    localparam int S  = 2;
    localparam int F  = 4;
    localparam int T  = 1000;
    localparam int HW = S + F;

    typedef struct {
        int hi;
        int lo;
        int edges;
        int per;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freq_in = 1'b0;
    logic [31:0] period;
    logic        valid;
    logic        timeout;
    logic [15:0] edge_count;

    logic        clk2 = 1'b0;
    logic        rst2 = 1'b1;
    logic        freq2 = 1'b0;
    logic [31:0] period2;
    logic        valid2;
    logic        timeout2;
    logic [15:0] edge_count2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    freqin #(.SYNC_STAGES(S), .FILTER(F), .TIMEOUT(32'(T))) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_in    (freq_in),
        .period     (period),
        .valid      (valid),
        .timeout    (timeout),
        .edge_count (edge_count)
    );

    freqin #(.SYNC_STAGES(2), .FILTER(1), .TIMEOUT(32'd16)) dut2 (
        .clk        (clk2),
        .rst        (rst2),
        .freq_in    (freq2),
        .period     (period2),
        .valid      (valid2),
        .timeout    (timeout2),
        .edge_count (edge_count2)
    );

    always #5 clk = ~clk;
    always #1 clk2 = ~clk2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: filtered level from a window of samples, period from edge timestamps.
    bit          hist[HW];
    bit          m_filt, m_pend, m_armed, m_flip;
    int          m_k, m_last;
    logic [31:0] e_period;
    logic        e_valid, e_timeout;
    logic [15:0] e_edges;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (hist[i]) hist[i] = 1'b0;
            m_filt = 0; m_pend = 0; m_armed = 0; m_k = 0; m_last = 0;
            e_period = '0; e_valid = 1'b0; e_timeout = 1'b0; e_edges = '0;
        end else begin
            m_k++;
            e_valid = 1'b0;
            if (m_pend) begin
                e_edges++;
                if (m_armed) begin
                    e_period  = 32'(m_k - m_last);
                    e_valid   = 1'b1;
                    e_timeout = 1'b0;
                end
                m_armed = 1;
                m_last  = m_k;
            end else if (m_armed && (m_k - m_last) == T) begin
                e_period  = '0;
                e_timeout = 1'b1;
                m_armed   = 0;
            end
            m_pend = 0;
            for (int i = 0; i < HW - 1; i++) hist[i] = hist[i+1];
            hist[HW-1] = freq_in;
            m_flip = 1;
            for (int i = 0; i < F; i++) if (hist[i] == m_filt) m_flip = 0;
            if (m_flip) begin
                m_filt = ~m_filt;
                m_pend = m_filt;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("valid", {31'd0, valid}, {31'd0, e_valid});
            check("period", period, e_period);
            check("timeout", {31'd0, timeout}, {31'd0, e_timeout});
            check("edge_count", {16'd0, edge_count}, {16'd0, e_edges});
        end
    end

    int          vcnt = 0;
    logic [31:0] vper = '0;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcnt++;
            vper = period;
        end
    end

    task automatic pulse(input int hi, input int lo);
        freq_in = 1'b1;
        repeat (hi) @(negedge clk);
        freq_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish, limit 20ms reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   e0, v0, lat, waited, hi, lo;
        tbl[0] = '{50, 50, 1, -1};
        tbl[1] = '{50, 50, 1, 100};
        tbl[2] = '{50, 50, 1, 100};
        tbl[3] = '{3, 97, 0, -1};
        tbl[4] = '{4, 96, 1, 200};
        tbl[5] = '{1, 99, 0, -1};
        tbl[6] = '{50, 50, 1, 200};
        tbl[7] = '{20, 80, 1, 100};

        repeat (3) @(negedge clk);
        check("rst_period", period, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_edge_count", {16'd0, edge_count}, 32'd0);
        rst  = 1'b0;
        rst2 = 1'b0;
        chk_en = 1'b1;

        repeat (T + 50) @(negedge clk);
        check("idle_no_timeout", {31'd0, timeout}, 32'd0);

        foreach (tbl[i]) begin
            e0 = int'(edge_count);
            v0 = vcnt;
            pulse(tbl[i].hi, tbl[i].lo);
            #1;
            check("tbl_edges", 32'(int'(edge_count) - e0), 32'(tbl[i].edges));
            check("tbl_valids", 32'(vcnt - v0), (tbl[i].per >= 0) ? 32'd1 : 32'd0);
            if (tbl[i].per >= 0) check("tbl_period", vper, 32'(tbl[i].per));
        end

        @(negedge clk);
        freq_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1 && lat == 0) lat = i;
        end
        check("latency", 32'(lat), 32'(S + F + 1));
        @(negedge clk);
        freq_in = 1'b0;
        repeat (50) @(negedge clk);

        repeat (3) pulse(50, 50);
        waited = 0;
        while (timeout !== 1'b1 && waited < 1500) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_set", {31'd0, timeout}, 32'd1);
        check("timeout_period", period, 32'd0);
        v0 = vcnt;
        pulse(50, 250);
        #1;
        check("rearm_no_valid", 32'(vcnt - v0), 32'd0);
        check("timeout_held", {31'd0, timeout}, 32'd1);
        v0 = vcnt;
        pulse(50, 50);
        #1;
        check("after_timeout_valids", 32'(vcnt - v0), 32'd1);
        check("after_timeout_period", vper, 32'd300);
        check("after_timeout_clear", {31'd0, timeout}, 32'd0);

        repeat (3) pulse(500, 500);
        #1;
        check("exact_T_period", vper, 32'(T));
        check("exact_T_timeout", {31'd0, timeout}, 32'd0);

        pulse(50, 50);
        @(negedge clk);
        freq_in = 1'b1;
        repeat (20) @(negedge clk);
        freq_in = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_period", period, 32'd0);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_timeout", {31'd0, timeout}, 32'd0);
        check("arst_edge_count", {16'd0, edge_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        v0 = vcnt;
        pulse(50, 50);
        #1;
        check("post_rst_no_valid", 32'(vcnt - v0), 32'd0);
        check("post_rst_edges", {16'd0, edge_count}, 32'd1);
        pulse(50, 50);
        #1;
        check("post_rst_period", vper, 32'd100);

        for (int i = 0; i < 40; i++) begin
            hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(4, 300));
            lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(4, 800));
            pulse(hi, lo);
        end
        repeat (T + 20) @(negedge clk);
        chk_en = 1'b0;

        @(negedge clk2);
        repeat (65536) begin
            freq2 = 1'b1;
            @(negedge clk2);
            freq2 = 1'b0;
            @(negedge clk2);
        end
        repeat (10) @(negedge clk2);
        check("wrap_zero", {16'd0, edge_count2}, 32'd0);
        freq2 = 1'b1;
        repeat (10) @(negedge clk2);
        freq2 = 1'b0;
        repeat (10) @(negedge clk2);
        check("wrap_one", {16'd0, edge_count2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
